// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg: shared widths and entry types for the register-file write-back controller
package regfile_wb_pkg;
  localparam int default_num_registers = 32;
  localparam int default_register_size = 32;
  localparam int default_fifo_depth = 2;
  localparam int addr_w = $clog2(default_num_registers);
  typedef logic [addr_w-1:0] addr_t;
  typedef struct packed {
    addr_t rd;
    logic [default_register_size-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_fifo.sv
// wb_fifo: circular buffer of write-back entries with push/pop and occupancy count
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int depth = default_fifo_depth,
  parameter type entry_t = wb_entry_t
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  entry_t din,
  output entry_t dout,
  output logic [$clog2(depth):0] count
);
  localparam int pw = $clog2(depth);
  entry_t mem [depth];
  logic [pw-1:0] wr_ptr, rd_ptr;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  // depth is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + pw'(push);
      rd_ptr <= rd_ptr + pw'(pop);
      count <= count + (pw + 1)'(push) - (pw + 1)'(pop);
    end
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU and buffered long-latency results into the register file write port.
// Define REGFILE_WB_SCOREBOARD_EN to build the pending-destination scoreboard driving busy_mask.
module regfile_writeback
  import regfile_wb_pkg::*;
#(
  parameter int num_registers = default_num_registers,
  parameter int register_size = default_register_size,
  parameter int fifo_depth = default_fifo_depth
) (
  input  logic clk,
  input  logic reset,
  input  logic alu_valid,
  input  logic [$clog2(num_registers)-1:0] alu_rd,
  input  logic [register_size-1:0] alu_data,
  input  logic lsu_issue,
  input  logic [$clog2(num_registers)-1:0] lsu_issue_rd,
  input  logic lsu_valid,
  input  logic [$clog2(num_registers)-1:0] lsu_rd,
  input  logic [register_size-1:0] lsu_data,
  output logic lsu_ready,
  output logic [$clog2(num_registers)-1:0] rd,
  output logic write_enable,
  output logic [register_size-1:0] write_data,
  output logic [num_registers-1:0] busy_mask,
  output logic [$clog2(fifo_depth):0] fifo_count
);
  localparam int aw = $clog2(num_registers);
  localparam int cw = $clog2(fifo_depth) + 1;
  localparam logic [cw-1:0] full = cw'(fifo_depth);
  typedef struct packed {
    logic [aw-1:0] rd;
    logic [register_size-1:0] data;
  } entry_t;
  entry_t head, sel_entry;
  logic push, pop, sel;
  // no pass-through when full: readiness depends on occupancy only
  assign lsu_ready = fifo_count < full;
  assign push = lsu_valid && lsu_ready;
  assign pop = !alu_valid && fifo_count != '0;
  assign sel = alu_valid || pop;
  assign sel_entry = alu_valid ? {alu_rd, alu_data} : head;
  wb_fifo #(.depth(fifo_depth), .entry_t(entry_t)) fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din({lsu_rd, lsu_data}),
    .dout(head),
    .count(fifo_count)
  );
  // x0 entries still advance rd/write_data and drain the FIFO, only the strobe is masked
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd <= '0;
      write_data <= '0;
      write_enable <= 1'b0;
    end else begin
      write_enable <= sel && sel_entry.rd != '0;
      if (sel) {rd, write_data} <= sel_entry;
    end
`ifdef REGFILE_WB_SCOREBOARD_EN
  localparam logic [num_registers-1:0] one = num_registers'(1);
  logic [num_registers-1:0] set_mask, clr_mask;
  assign set_mask = (lsu_issue && lsu_issue_rd != '0) ? one << lsu_issue_rd : '0;
  assign clr_mask = pop ? one << head.rd : '0;
  // set applied after clear so a same-cycle issue keeps the bit busy
  always_ff @(posedge clk or posedge reset)
    if (reset) busy_mask <= '0;
    else busy_mask <= (busy_mask & ~clr_mask) | set_mask;
`else
  logic unused_issue;
  assign unused_issue = ^{lsu_issue, lsu_issue_rd};
  assign busy_mask = '0;
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: randomized and directed checks of regfile_writeback against a queue-based model
module tb_regfile_writeback;
  localparam int nr = 32, dw = 32, depth = 2, aw = 5, cw = 2;
  localparam int sw = 1 + aw + dw + nr + cw + 1;
`ifdef REGFILE_WB_SCOREBOARD_EN
  localparam bit sb = 1'b1;
`else
  localparam bit sb = 1'b0;
`endif
  localparam logic [sw-1:0] reset_state = {1'b0, 5'd0, 32'd0, 32'd0, 2'd0, 1'b1};
  logic clk = 1'b0, reset = 1'b1;
  logic alu_valid = 0, lsu_issue = 0, lsu_valid = 0;
  logic [aw-1:0] alu_rd = 0, lsu_issue_rd = 0, lsu_rd = 0;
  logic [dw-1:0] alu_data = 0, lsu_data = 0;
  logic lsu_ready, write_enable;
  logic [aw-1:0] rd;
  logic [dw-1:0] write_data;
  logic [nr-1:0] busy_mask;
  logic [cw-1:0] fifo_count;
  int checks = 0, errors = 0;
  logic [aw+dw-1:0] q[$];
  logic m_we, m_acc;
  logic [aw-1:0] m_rd;
  logic [dw-1:0] m_wd;
  logic [nr-1:0] m_bm;

  always #5 clk = ~clk;

  regfile_writeback dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_issue(lsu_issue), .lsu_issue_rd(lsu_issue_rd),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .lsu_ready(lsu_ready), .rd(rd), .write_enable(write_enable),
    .write_data(write_data), .busy_mask(busy_mask), .fifo_count(fifo_count)
  );

  function automatic logic [sw-1:0] obs();
    return {write_enable, rd, write_data, busy_mask, fifo_count, lsu_ready};
  endfunction

  function automatic logic [sw-1:0] expect_state();
    return {m_we, m_rd, m_wd, m_bm, cw'(q.size()), q.size() < depth};
  endfunction

  task automatic model_reset();
    q.delete();
    m_we = 0; m_rd = 0; m_wd = 0; m_bm = 0; m_acc = 0;
  endtask

  // drive one cycle of inputs, advance the model, and land #1 after the edge
  task automatic drive(input logic av, input logic [aw-1:0] ard, input logic [dw-1:0] ad,
                       input logic iss, input logic [aw-1:0] ird,
                       input logic lv, input logic [aw-1:0] lrd, input logic [dw-1:0] ld);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_issue = iss; lsu_issue_rd = ird;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    m_acc = lv && q.size() < depth;
    m_we = 0;
    if (av) begin
      m_rd = ard; m_wd = ad; m_we = ard != 0;
    end else if (q.size() > 0) begin
      {m_rd, m_wd} = q.pop_front();
      m_we = m_rd != 0;
      if (sb) m_bm[m_rd] = 1'b0;
    end
    if (m_acc) q.push_back({lrd, ld});
    if (sb && iss && ird != 0) m_bm[ird] = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs() !== reset_state) begin
      errors++; $display("FAIL reset_state got=%h want=%h", obs(), reset_state);
    end
    @(negedge clk); reset = 0;
    model_reset();
  endtask

  task automatic test_alu();
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    checks++;
    if ({write_enable, rd, write_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      errors++; $display("FAIL alu_write got=%b/%0d/%h want=1/5/deadbeef", write_enable, rd, write_data);
    end
    idle();
    checks++;
    if ({write_enable, rd, write_data} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
      errors++; $display("FAIL alu_idle_hold got=%b/%0d/%h want=0/5/deadbeef", write_enable, rd, write_data);
    end
  endtask

  task automatic test_lsu_path();
    drive(0, 0, 0, 1, 7, 0, 0, 0);
    checks++;
    if (busy_mask !== (sb ? nr'(1) << 7 : nr'(0))) begin
      errors++; $display("FAIL busy_set got=%h want_bit7=%0d", busy_mask, sb);
    end
    drive(0, 0, 0, 0, 0, 1, 7, 32'h1234);
    checks++;
    if ({write_enable, fifo_count, busy_mask[7]} !== {1'b0, 2'd1, sb}) begin
      errors++; $display("FAIL lsu_accept got=%b/%0d/%b want=0/1/%0d", write_enable, fifo_count, busy_mask[7], sb);
    end
    idle();
    checks++;
    if ({write_enable, rd, write_data, fifo_count, busy_mask[7]} !== {1'b1, 5'd7, 32'h1234, 2'd0, 1'b0}) begin
      errors++; $display("FAIL lsu_write got=%b/%0d/%h/%0d/%b want=1/7/1234/0/0",
                         write_enable, rd, write_data, fifo_count, busy_mask[7]);
    end
    idle();
    checks++;
    if (obs() !== expect_state()) begin
      errors++; $display("FAIL lsu_after got=%h want=%h", obs(), expect_state());
    end
  endtask

  task automatic test_back_to_back();
    logic [dw-1:0] d [3];
    int k = 0;
    for (int i = 0; i < 3; i++) d[i] = $urandom;
    for (int i = 0; i < 4; i++) begin
      drive(1, aw'(10 + i), $urandom, 0, 0, k < 3, aw'(20 + k), d[k < 3 ? k : 2]);
      if (m_acc) k++;
      checks++;
      if (obs() !== expect_state()) begin
        errors++; $display("FAIL b2b_alu%0d got=%h want=%h", i, obs(), expect_state());
      end
      if (i == 1) begin
        checks++;
        if ({lsu_ready, fifo_count} !== {1'b0, 2'd2}) begin
          errors++; $display("FAIL b2b_full got=%b/%0d want=0/2", lsu_ready, fifo_count);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, k < 3, aw'(20 + k), d[k < 3 ? k : 2]);
      if (m_acc) k++;
      checks++;
      if (obs() !== expect_state()) begin
        errors++; $display("FAIL b2b_drain%0d got=%h want=%h", i, obs(), expect_state());
      end
      if (i < 3) begin
        checks++;
        if ({write_enable, rd, write_data} !== {1'b1, aw'(20 + i), d[i]}) begin
          errors++; $display("FAIL b2b_order%0d got=%b/%0d/%h want=1/%0d/%h", i, write_enable, rd, write_data, 20 + i, d[i]);
        end
      end
    end
  endtask

  task automatic test_x0();
    drive(1, 0, 32'hFF, 0, 0, 1, 0, 32'hAB);
    checks++;
    if (write_enable !== 1'b0) begin
      errors++; $display("FAIL x0_alu got=%b want=0", write_enable);
    end
    for (int i = 0; i < 2; i++) begin
      idle();
      checks++;
      if (write_enable !== 1'b0) begin
        errors++; $display("FAIL x0_lsu%0d got=%b want=0", i, write_enable);
      end
    end
    checks++;
    if ({fifo_count, rd, write_data} !== {2'd0, 5'd0, 32'hAB}) begin
      errors++; $display("FAIL x0_drain got=%0d/%0d/%h want=0/0/ab", fifo_count, rd, write_data);
    end
  endtask

  task automatic test_reset_flush();
    drive(0, 0, 0, 1, 7, 0, 0, 0);
    drive(1, 1, 32'h11, 0, 0, 1, 7, 32'h77);
    drive(1, 2, 32'h22, 0, 0, 1, 7, 32'h78);
    checks++;
    if ({fifo_count, busy_mask} !== {2'd2, sb ? 32'h80 : 32'h0}) begin
      errors++; $display("FAIL flush_setup got=%0d/%h want=2/%h", fifo_count, busy_mask, sb ? 32'h80 : 32'h0);
    end
    alu_valid = 0; lsu_valid = 0; lsu_issue = 0;
    #1 reset = 1;
    #1;
    checks++;
    if (obs() !== reset_state) begin
      errors++; $display("FAIL flush_async got=%h want=%h", obs(), reset_state);
    end
    @(posedge clk);
    @(negedge clk); reset = 0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++;
      if (obs() !== reset_state) begin
        errors++; $display("FAIL flush_after%0d got=%h want=%h", i, obs(), reset_state);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 2) == 0, aw'($urandom), $urandom,
            $urandom_range(0, 1), aw'($urandom),
            $urandom_range(0, 1), aw'($urandom), $urandom);
      checks++;
      if (obs() !== expect_state()) begin
        errors++; $display("FAIL random%0d got=%h want=%h", i, obs(), expect_state());
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lsu_path();
    test_back_to_back();
    test_x0();
    test_reset_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side controller for the CPU register file. It merges single-cycle ALU results and long-latency results into the file's single write port. Long-latency results come from load/multiply units over a valid/ready handshake and are buffered in a small FIFO. A pending-destination scoreboard is kept for the issue stage. It sits between the execute/memory units and the register file, and drives the file's destination address, write enable and write data.

## Interface
- num_registers, 32, architectural register count; address width is $clog2(num_registers)
- register_size, 32, data width
- fifo_depth, 2, long-latency buffer depth; power of two, ≥2
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  $clog2(num_registers)  ALU destination
- alu_data  in  register_size  ALU result
- lsu_issue  in  1  long-latency op issued this cycle
- lsu_issue_rd  in  $clog2(num_registers)  its destination
- lsu_valid  in  1  long-latency result offered
- lsu_rd  in  $clog2(num_registers)  result destination
- lsu_data  in  register_size  result value
- lsu_ready  out  1  FIFO can accept
- rd  out  $clog2(num_registers)  to register file
- write_enable  out  1  to register file
- write_data  out  register_size  to register file
- busy_mask  out  num_registers  bit i = register i has a pending long-latency write
- fifo_count  out  $clog2(fifo_depth)+1  current occupancy

## Operation
- Long-latency result accepted on a clk edge when lsu_valid && lsu_ready; the {lsu_rd, lsu_data} entry is pushed to the FIFO.
- lsu_ready = (fifo_count < fifo_depth), combinational from the count only. No pass-through when full, even if a pop occurs the same cycle.
- Arbitration each cycle:
  - alu_valid high → ALU wins and the FIFO holds.
  - alu_valid low and FIFO non-empty → pop the head.
  - Otherwise idle.
- ALU results are never stalled; the upstream guarantees no backpressure is needed.
- Selected source is registered into rd/write_data. write_enable = selected && rd != 0. Writes to x0 are suppressed, but the FIFO entry is still consumed.
- Idle cycle: write_enable=0; rd/write_data hold their last value.
- Scoreboard:
  - lsu_issue with lsu_issue_rd != 0 sets busy_mask[lsu_issue_rd].
  - A FIFO pop clears busy_mask[popped rd].
  - Set and clear of the same bit in the same cycle → set wins.
  - busy_mask[0] is always 0.
- Push and pop in the same cycle → count unchanged. Pointers wrap modulo fifo_depth.

## Timing
- Reset values: write_enable=0, rd=0, write_data=0, busy_mask=0, fifo_count=0, lsu_ready=1. Asserting reset mid-operation flushes the FIFO and scoreboard immediately; in-flight entries are lost.
- ALU path latency is 1: alu_valid in cycle t → write_enable in cycle t+1, and the register file captures at the end of t+1.
- LSU path latency is ≥2: accepted at the edge ending cycle t → earliest write_enable in cycle t+2. Each consecutive alu_valid cycle delays it by one more.
- busy_mask updates on the edge after lsu_issue, and clears on the edge that pops the entry, i.e. the same edge that raises write_enable for it.
- fifo_count reflects pushes and pops on the following cycle.

## Configuration
- REGFILE_WB_SCOREBOARD_EN defined: scoreboard present as described.
- Not defined: busy_mask tied to 0, lsu_issue and lsu_issue_rd ignored, and no scoreboard flops are synthesised. The write path is unchanged.

## Structure
- Package regfile_wb_pkg:
  - wb_entry_t packed struct {rd, data}
  - default width constants
  - addr_t typedef
- Sub-module wb_fifo: generic circular buffer of wb_entry_t with push/pop/count, parameterised by depth.
- Arbitration, output register and scoreboard live in the top module.

## Test plan
- Reset, then alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle → next cycle write_enable=1, rd=5, write_data=0xDEADBEEF; the cycle after, write_enable=0.
- lsu_issue_rd=7, then lsu_valid with rd=7, data=0x1234 and alu_valid low → busy_mask[7]=1 until the write cycle; write_enable appears 2 cycles after accept; busy_mask[7]=0 in the write cycle.
- Hold alu_valid high for 4 cycles while pushing 3 LSU results → lsu_ready drops after 2 pushes; the third is held until a pop. The FIFO drains in order after ALU traffic stops, and fifo_count goes 2→1→0.
- ALU write with rd=0, data=0xFF, and LSU entry with rd=0 → write_enable never asserts; fifo_count returns to 0.
- Assert reset with 2 FIFO entries and busy_mask=0x80 → all outputs return to reset values at once, and no write occurs after release.
- Build without REGFILE_WB_SCOREBOARD_EN; pulse lsu_issue_rd=3 → busy_mask stays 0; write path results are identical to the first two scenarios.
